call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of return-address entries; power of two, 2..64.
REQ-002 Parameter WIDTH, default 12, entry width, equal to the PC width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 push  input  1  push push_data this cycle (call).
REQ-006 pop  input  1  pop top entry this cycle (return).
REQ-007 push_data  input  WIDTH  return address to store (pc+1).
REQ-008 err_clr  input  1  clears sticky ovf/unf.
REQ-009 top_data  output  WIDTH  current top entry; combinational from stored state.
REQ-010 count  output  log2(DEPTH)+1  number of valid entries.
REQ-011 empty  output  1  count==0.
REQ-012 full  output  1  count==DEPTH.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 unf  output  1  sticky underflow flag.

Function
REQ-015 State updates only on rising clk; top_data, empty and full SHALL be combinational from registered state, with no input-to-output path.
REQ-016 top_data SHALL equal the most recently pushed, unpopped entry; 0 when empty.
REQ-017 Push only, not full: entry written at stack pointer, pointer +1 mod DEPTH, count +1; new value on top_data the next cycle.
REQ-018 Pop only, not empty: pointer -1 mod DEPTH, count -1; the value popped is top_data during the pop cycle, so the caller samples it in that cycle.
REQ-019 Push and pop together, not empty: the top entry is replaced by push_data; pointer and count unchanged; no flag set, including when full.
REQ-020 Push and pop together, empty: treated as push only; unf not set.
REQ-021 Pop only, empty: no state change; top_data stays 0; unf behaviour per REQ-027/028.
REQ-022 Push only, full: behaviour per REQ-027/028.
REQ-023 err_clr clears ovf and unf on the next edge; if a new error occurs in the same cycle, the set wins.
REQ-024 Neither push nor pop: hold all state.

Reset
REQ-025 reset==0 at a rising edge: pointer=0, count=0, ovf=0, unf=0, so empty=1, full=0, top_data=0; this overrides push, pop and err_clr in that cycle.
REQ-026 Entry storage is not cleared by reset; stale entries are never visible because top_data is masked to 0 when empty.

Configuration
REQ-027 Macro CALL_STACK_ERR_EN defined: push on full is dropped and sets ovf; pop on empty sets unf; both flags hold until err_clr or reset.
REQ-028 Macro CALL_STACK_ERR_EN undefined: push on full overwrites the oldest entry (circular); the pointer advances and count stays DEPTH; pop on empty is ignored; ovf and unf are tied to 0 and err_clr is ignored; the port list is identical in both builds.

Structure
REQ-029 Shared package call_stack_pkg SHALL hold CS_DEPTH=8, CS_WIDTH=12 and the operation enum {CS_IDLE, CS_PUSH, CS_POP, CS_REPL} decoded from {push,pop,empty}.
REQ-030 Storage SHALL be the sub-module call_stack_ram: DEPTH x WIDTH registers, one synchronous write port and one asynchronous read port; pointer, count and flag logic stay in call_stack.

Verification
REQ-031 Reset, then push 0x010, 0x020, 0x030 -> count=3, top_data=0x030; pop returns 0x030, then 0x020, then 0x010; then empty=1 and top_data=0.
REQ-032 Push 0x100 then push+pop with 0x2AB -> top_data=0x2AB, count=1, ovf=unf=0.
REQ-033 ERR_EN build: push 8 entries 0x001..0x008, then push 0x0FF -> full=1, ovf=1, top_data=0x008; err_clr -> ovf=0 next cycle.
REQ-034 Non-ERR_EN build: push 0x001..0x009 -> count=8, ovf=0; eight pops return 0x009..0x002.
REQ-035 Pop when empty -> count=0, top_data=0; unf=1 (ERR_EN build) or unf=0 (non-ERR_EN build); err_clr and pop on empty in the same cycle -> unf=1.
REQ-036 Push 2 entries, hold reset=0 for one edge while push=1 -> count=0, empty=1, flags=0, top_data=0.

Source files
------------

// File: rtl/call_stack_pkg.sv
//------------------------------------------------------------------------------
// Module   : call_stack_pkg
// Purpose  : Shared constants, the operation type and the operation decoder
//            for the hardware return-address stack.
// Contents : CS_DEPTH, CS_WIDTH (default geometry), cs_op_e, cs_decode()
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package call_stack_pkg;

  localparam int CS_DEPTH = 8;
  localparam int CS_WIDTH = 12;

  // Effective operation for one cycle.
  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_PUSH = 2'd1,
    CS_POP  = 2'd2,
    CS_REPL = 2'd3
  } cs_op_e;

  // Push+pop on a non-empty stack replaces the top.
  // Push+pop on an empty stack degenerates to a plain push.
  // Pop on an empty stack is IDLE; the caller flags underflow separately.
  function automatic cs_op_e cs_decode(input logic push, input logic pop,
                                       input logic empty);
    cs_op_e op;
    op = CS_IDLE;
    if (push && pop && !empty) begin
      op = CS_REPL;
    end else if (push) begin
      op = CS_PUSH;
    end else if (pop && !empty) begin
      op = CS_POP;
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/call_stack_if.sv
//------------------------------------------------------------------------------
// Module   : call_stack_if
// Purpose  : Bundles the call/return request and status signals of the
//            return-address stack.
// Signals  : push, pop, push_data, err_clr  (master -> slave)
//            top_data, count, empty, full, ovf, unf  (slave -> master)
// Modports : master (requester), slave (call_stack)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int DEPTH = CS_DEPTH,
  parameter int WIDTH = CS_WIDTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             err_clr;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, push_data, err_clr,
    input  top_data, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output top_data, count, empty, full, ovf, unf
  );

endinterface

`default_nettype wire

// File: rtl/call_stack_ram.sv
//------------------------------------------------------------------------------
// Module   : call_stack_ram
// Purpose  : DEPTH x WIDTH register file backing the return-address stack.
//            One synchronous write port, one asynchronous read port.
//            Contents are deliberately not reset.
// Ports    : clk      - rising-edge clock
//            i_we     - write enable
//            i_waddr  - write address
//            i_wdata  - write data
//            i_raddr  - read address
//            o_rdata  - read data (combinational)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module call_stack_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  wire logic                     clk,
  input  wire logic                     i_we,
  input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
  input  wire logic [WIDTH-1:0]         i_wdata,
  input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic      [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/call_stack.sv
//------------------------------------------------------------------------------
// Module   : call_stack
// Purpose  : Hardware return-address stack (call pushes pc+1, return pops).
//            Pointer, count and error-flag logic; storage in call_stack_ram.
// Ports    : clk    - rising-edge clock
//            reset  - synchronous, active-low reset
//            bus    - call_stack_if.slave (push/pop/push_data/err_clr in,
//                     top_data/count/empty/full/ovf/unf out)
// Config   : CALL_STACK_ERR_EN defined   -> push on full is dropped and sets
//                                           sticky ovf; pop on empty sets
//                                           sticky unf.
//            CALL_STACK_ERR_EN undefined -> push on full overwrites the
//                                           oldest entry; ovf/unf tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module call_stack
  import call_stack_pkg::*;
#(
  parameter int DEPTH = CS_DEPTH,
  parameter int WIDTH = CS_WIDTH
) (
  input wire logic     clk,
  input wire logic     reset,
  call_stack_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // r_sp points at the next free slot; the top entry lives at r_sp-1.
  logic [PW-1:0] r_sp;
  logic [CW-1:0] r_count;

  logic [PW-1:0]    w_sp_n;
  logic [CW-1:0]    w_count_n;
  logic [PW-1:0]    w_top_idx;
  logic [PW-1:0]    w_waddr;
  logic             w_we;
  logic             w_empty;
  logic             w_full;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [WIDTH-1:0] w_rdata;
  cs_op_e           w_op;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_top_idx = r_sp - PW'(1);
  assign w_op      = cs_decode(bus.push, bus.pop, w_empty);

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_sp;
    w_sp_n    = r_sp;
    w_count_n = r_count;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_op)
      CS_PUSH: begin
        if (!w_full) begin
          w_we      = 1'b1;
          w_sp_n    = r_sp + PW'(1);
          w_count_n = r_count + CW'(1);
        end else begin
`ifdef CALL_STACK_ERR_EN
          w_ovf_set = 1'b1;
`else
          // When full, r_sp addresses the oldest entry, so a plain write
          // there plus pointer advance gives circular overwrite.
          w_we   = 1'b1;
          w_sp_n = r_sp + PW'(1);
`endif
        end
      end
      CS_POP: begin
        w_sp_n    = w_top_idx;
        w_count_n = r_count - CW'(1);
      end
      CS_REPL: begin
        w_we    = 1'b1;
        w_waddr = w_top_idx;
      end
      CS_IDLE: begin
`ifdef CALL_STACK_ERR_EN
        // IDLE with pop asserted can only mean pop on an empty stack.
        w_unf_set = bus.pop;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sp    <= '0;
      r_count <= '0;
    end else begin
      r_sp    <= w_sp_n;
      r_count <= w_count_n;
    end
  end

  call_stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we & reset),
    .i_waddr (w_waddr),
    .i_wdata (bus.push_data),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  // Storage is never cleared, so stale data is hidden while empty.
  assign bus.top_data = w_empty ? '0 : w_rdata;
  assign bus.count    = r_count;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;

`ifdef CALL_STACK_ERR_EN
  logic r_ovf;
  logic r_unf;

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~bus.err_clr) | w_ovf_set;
      r_unf <= (r_unf & ~bus.err_clr) | w_unf_set;
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.unf = r_unf;
`else
  logic w_unused;
  assign w_unused = &{1'b0, bus.err_clr, w_ovf_set, w_unf_set};
  assign bus.ovf  = 1'b0;
  assign bus.unf  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_call_stack.sv
//------------------------------------------------------------------------------
// Module   : tb_call_stack
// Purpose  : Self-checking bench for call_stack. A queue-based stack model
//            predicts every cycle's outputs; predictions go to a scoreboard
//            that a separate monitor drains on the falling clock edge.
// Config   : honours CALL_STACK_ERR_EN the same way as the design.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_call_stack;
  import call_stack_pkg::*;

  localparam int DEPTH = CS_DEPTH;
  localparam int WIDTH = CS_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  call_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] top;
    logic [31:0] cnt;
    logic [31:0] emp;
    logic [31:0] ful;
    logic [31:0] ov;
    logic [31:0] un;
    string       tag;
  } exp_t;

  exp_t sb[$];

  // Reference model: a plain queue, newest entry at the back.
  int stk[$];
  bit m_ovf, m_unf, known;
  int checks = 0;
  int errors = 0;

  function automatic void model_update(bit p, bit q, int d, bit clr, bit rst);
    int v;
    v = d & ((1 << WIDTH) - 1);
    if (!rst) begin
      stk.delete();
      m_ovf = 0;
      m_unf = 0;
      known = 1;
      return;
    end
`ifdef CALL_STACK_ERR_EN
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
`endif
    if (p && q && stk.size() > 0) begin
      stk[stk.size()-1] = v;
    end else if (p) begin
      if (stk.size() < DEPTH) begin
        stk.push_back(v);
      end else begin
`ifdef CALL_STACK_ERR_EN
        m_ovf = 1;
`else
        void'(stk.pop_front());
        stk.push_back(v);
`endif
      end
    end else if (q) begin
      if (stk.size() > 0) begin
        void'(stk.pop_back());
      end else begin
`ifdef CALL_STACK_ERR_EN
        m_unf = 1;
`endif
      end
    end
  endfunction

  // Drive one cycle: present inputs, queue the prediction for this cycle's
  // outputs, then advance the model across the rising edge.
  task automatic step(bit p, bit q, int d, bit clr, bit rst, string tag);
    exp_t e;
    reset         = rst;
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d[WIDTH-1:0];
    bus.err_clr   = clr;
    if (known) begin
      e.top = (stk.size() > 0) ? stk[stk.size()-1] : 0;
      e.cnt = stk.size();
      e.emp = (stk.size() == 0) ? 1 : 0;
      e.ful = (stk.size() == DEPTH) ? 1 : 0;
      e.ov  = m_ovf;
      e.un  = m_unf;
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    model_update(p, q, d, clr, rst);
    #1;
  endtask

  task automatic chk(string name, string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h expected=%0h", tag, name, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("top_data", e.tag, 32'(bus.top_data), e.top);
      chk("count",    e.tag, 32'(bus.count),    e.cnt);
      chk("empty",    e.tag, 32'(bus.empty),    e.emp);
      chk("full",     e.tag, 32'(bus.full),     e.ful);
      chk("ovf",      e.tag, 32'(bus.ovf),      e.ov);
      chk("unf",      e.tag, 32'(bus.unf),      e.un);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit p, q, c, r;
    reset         = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
    bus.err_clr   = 1'b0;
    known         = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, "rst");
    step(0, 0, 0, 0, 1, "rst_state");

    // Basic LIFO order
    step(1, 0, 'h010, 0, 1, "push1");
    step(1, 0, 'h020, 0, 1, "push2");
    step(1, 0, 'h030, 0, 1, "push3");
    step(0, 0, 0, 0, 1, "three");
    step(0, 1, 0, 0, 1, "pop30");
    step(0, 1, 0, 0, 1, "pop20");
    step(0, 1, 0, 0, 1, "pop10");
    step(0, 0, 0, 0, 1, "drained");

    // Replace-top
    step(1, 0, 'h100, 0, 1, "push100");
    step(1, 1, 'h2AB, 0, 1, "repl");
    step(0, 0, 0, 0, 1, "repl_chk");
    step(0, 1, 0, 0, 1, "pop2ab");
    step(1, 1, 'h055, 0, 1, "repl_empty");
    step(0, 1, 0, 0, 1, "pop055");

    // Fill past capacity
    for (int i = 1; i <= DEPTH + 1; i++) step(1, 0, i, 0, 1, "fill");
    step(0, 0, 0, 0, 1, "overfull");
    step(1, 1, 'h3CC, 0, 1, "repl_full");
    step(0, 0, 0, 1, 1, "clr_ovf");
    step(0, 0, 0, 0, 1, "after_clr");
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 1, "unwind");

    // Underflow
    step(0, 1, 0, 0, 1, "pop_empty");
    step(0, 1, 0, 1, 1, "clr_and_unf");
    step(0, 0, 0, 0, 1, "unf_held");
    step(0, 0, 0, 1, 1, "clr_unf");

    // Reset overrides push
    step(1, 0, 'h111, 0, 1, "pre_rst1");
    step(1, 0, 'h222, 0, 1, "pre_rst2");
    step(1, 0, 'h333, 0, 0, "rst_push");
    step(0, 0, 0, 0, 1, "post_rst");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 63) != 0);
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 8);
      step(p, q, int'($urandom), c, r, "rand");
    end
    step(0, 0, 0, 0, 1, "final");

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
